// File: rtl/seq_dibit_feeder.sv
// Byte FIFO feeding a 2-bit-per-clock serialiser; back-to-back bytes give a gap-free
// dibit stream for the downstream sequence checker.
module seq_dibit_feeder #(
   parameter int DEPTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [1:0]               dibit_out,
   output logic                     dibit_valid,
   output logic [$clog2(DEPTH):0]   fifo_level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic [7:0]    r_shift;
   logic [1:0]    r_phase;
   logic          r_busy;
   logic [1:0]    r_dibit;
   logic          r_valid;

   logic          w_push;
   logic          w_pop;
   logic          w_last;
   logic [7:0]    w_head;

   // Symbol idx (0..3) of byte b in emission order.
   function automatic logic [1:0] sym(input logic [7:0] b, input logic [1:0] idx);
      logic [1:0] pos;
      pos = MSB_FIRST ? ~idx : idx;
      return b[{pos, 1'b0} +: 2];
   endfunction

   assign in_ready = !rst && (r_level < LVL_FULL);
   assign w_push   = in_valid && in_ready;
   assign w_last   = (r_phase == 2'd3);
   // Load uses the registered level, so a byte pushed this edge waits one cycle.
   assign w_pop    = (r_level != '0) && (!r_busy || w_last);
   assign w_head   = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift <= '0;
         r_phase <= '0;
         r_busy  <= 1'b0;
         r_dibit <= '0;
         r_valid <= 1'b0;
      end else if (w_pop) begin
         r_shift <= w_head;
         r_phase <= 2'd0;
         r_busy  <= 1'b1;
         r_dibit <= sym(w_head, 2'd0);
         r_valid <= 1'b1;
      end else if (r_busy && !w_last) begin
         r_phase <= r_phase + 2'd1;
         r_dibit <= sym(r_shift, r_phase + 2'd1);
         r_valid <= 1'b1;
      end else if (r_busy) begin
         r_phase <= 2'd0;
         r_busy  <= 1'b0;
         r_dibit <= 2'b00;
         r_valid <= 1'b0;
      end
   end

   assign dibit_out   = r_dibit;
   assign dibit_valid = r_valid;
   assign fifo_level  = r_level;

endmodule

// File: tb/tb_seq_dibit_feeder.sv
// Bench for seq_dibit_feeder: two instances (MSB-first and LSB-first) share stimulus and
// are checked every cycle against a queue-based model, plus literal symbol streams.
module tb_seq_dibit_feeder;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       rdy1, rdy0, val1, val0;
   logic [1:0] d1, d0;
   logic [2:0] lv1, lv0;

   always #5 clk = ~clk;

   seq_dibit_feeder #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
      .dibit_out(d1), .dibit_valid(val1), .fifo_level(lv1)
   );
   seq_dibit_feeder #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
      .dibit_out(d0), .dibit_valid(val0), .fifo_level(lv0)
   );

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   // Model: queue of buffered bytes, plus the byte on the wire and its symbol index.
   byte unsigned m_q[$];
   byte unsigned m_cur = 8'h00;
   bit m_busy = 1'b0;
   int m_k = 0;

   int cap1[$];
   int cap0[$];
   int capc[$];
   int max_lvl = 0;
   bit saw_full = 1'b0;
   int last_acc = 0;

   function automatic int sym_of(input int b, input int k, input bit msb);
      int sh;
      sh = msb ? (6 - 2 * k) : (2 * k);
      return (b >> sh) & 3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic check_q(input string name, input int act[$], input string exp);
      check({name, "_len"}, act.size(), exp.len());
      for (int i = 0; i < exp.len() && i < act.size(); i++) begin
         check(name, act[i], int'(exp[i]) - 48);
      end
   endtask

   task automatic check_contig(input string name);
      if (capc.size() > 0) begin
         check(name, capc[capc.size()-1] - capc[0], capc.size() - 1);
      end
   endtask

   task automatic clear_caps();
      cap1.delete();
      cap0.delete();
      capc.delete();
      max_lvl = 0;
      saw_full = 1'b0;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int w;
      in_data = b;
      in_valid = 1'b1;
      w = 0;
      @(negedge clk);
      #1;
      while (!rdy1 && w < 100) begin
         @(negedge clk);
         #1;
         w++;
      end
      check("accept_wait", (w < 100), 1);
      @(posedge clk);
      #2;
      last_acc = cyc;
      in_valid = 1'b0;
   endtask

   initial begin : model
      bit acc;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            m_q.delete();
            m_busy = 1'b0;
            m_k = 0;
         end else begin
            acc = in_valid && (m_q.size() < DEPTH);
            if (m_q.size() > 0 && (!m_busy || m_k == 3)) begin
               m_cur = m_q.pop_front();
               m_k = 0;
               m_busy = 1'b1;
            end else if (m_busy && m_k < 3) begin
               m_k++;
            end else begin
               m_busy = 1'b0;
            end
            if (acc) m_q.push_back(in_data);
         end
      end
   end

   initial begin : compare
      int er;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            er = (!rst && m_q.size() < DEPTH) ? 1 : 0;
            check("in_ready_msb", rdy1, er);
            check("in_ready_lsb", rdy0, er);
            check("dibit_valid_msb", val1, m_busy);
            check("dibit_valid_lsb", val0, m_busy);
            check("dibit_out_msb", d1, m_busy ? sym_of(m_cur, m_k, 1'b1) : 0);
            check("dibit_out_lsb", d0, m_busy ? sym_of(m_cur, m_k, 1'b0) : 0);
            check("fifo_level_msb", lv1, m_q.size());
            check("fifo_level_lsb", lv0, m_q.size());
            if (val1 === 1'b1) begin
               cap1.push_back(int'(d1));
               capc.push_back(cyc);
            end
            if (val0 === 1'b1) cap0.push_back(int'(d0));
            if (int'(lv1) > max_lvl) max_lvl = int'(lv1);
            if (lv1 == 3'(DEPTH) && rdy1 == 1'b0) saw_full = 1'b1;
         end
      end
   end

   initial begin : stim
      int w;
      int p;
      // Reset held with a valid byte offered: nothing may be accepted.
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 8'hFF;
      @(posedge clk);
      #2;
      chk_en = 1'b1;
      cycles(3);
      rst = 1'b0;
      in_valid = 1'b0;
      clear_caps();
      cycles(10);
      check("no_emit_after_reset", cap1.size(), 0);

      // Single byte, both orders, latency pinned.
      clear_caps();
      send_byte(8'hB2);
      cycles(10);
      check_q("single_msb", cap1, "2302");
      check_q("single_lsb", cap0, "2032");
      if (capc.size() > 0) check("single_latency", capc[0], last_acc + 1);
      check_contig("single_contig");

      // Back-to-back bytes.
      clear_caps();
      send_byte(8'hB2);
      send_byte(8'hB3);
      send_byte(8'h5A);
      cycles(20);
      check_q("b2b_msb", cap1, "230223031122");
      check_contig("b2b_contig");
      check("b2b_peak_level", max_lvl, 2);

      // Backpressure with 8 bytes offered continuously.
      clear_caps();
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      cycles(50);
      check_q("bp_msb", cap1, "00010002000300100011001200130020");
      check_contig("bp_contig");
      check("bp_peak_level", max_lvl, 4);
      check("bp_ready_low_when_full", saw_full, 1);

      // Reset while the first byte is at phase 2.
      clear_caps();
      send_byte(8'hB2);
      send_byte(8'hC3);
      w = 0;
      while (cap1.size() < 3 && w < 50) begin
         @(negedge clk);
         #1;
         w++;
      end
      check("midrst_wait", (w < 50), 1);
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      cycles(5);
      send_byte(8'h0F);
      cycles(12);
      check_q("midrst_msb", cap1, "2300033");

      // Randomised traffic with occasional resets.
      for (int blk = 0; blk < 10; blk++) begin
         p = $urandom_range(100, 5);
         for (int i = 0; i < 200; i++) begin
            in_valid = ($urandom_range(99) < p);
            in_data = 8'($urandom);
            rst = ($urandom_range(299) == 0);
            @(posedge clk);
            #2;
         end
      end
      rst = 1'b0;
      in_valid = 1'b0;
      cycles(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
